// File: rtl/sfifo_param.sv
// sfifo_param: single-clock parameterised FIFO with registered read data and occupancy status flags.
// Defining SFIFO_ERR_EN adds sticky overflow/underflow error flags (tied low otherwise).
module sfifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_wreq,
  input  logic                     i_rreq,
  input  logic [WIDTH-1:0]         Data_in,
  output logic [WIDTH-1:0]         Data_out,
  output logic                     o_rvalid,
  output logic                     fifoisfull,
  output logic                     fifoisempty,
  output logic                     fifo_afull,
  output logic                     fifo_aempty,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     o_ovf,
  output logic                     o_udf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V     = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_V     = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_V    = (AW+1)'(AEMPTY_TH);
  localparam logic [AW:0] CNT_ONE     = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nxt_s;
  logic [WIDTH-1:0] data_out_r;
  logic             rvalid_r;
  logic             full_s;
  logic             empty_s;
  logic             wr_acc_s;
  logic             rd_acc_s;

  // Status is decoded purely from the occupancy counter, never from the request inputs.
  assign full_s      = (count_r == DEPTH_V);
  assign empty_s     = (count_r == {(AW+1){1'b0}});
  assign fifoisfull  = full_s;
  assign fifoisempty = empty_s;
  assign fifo_afull  = (count_r >= AFULL_V);
  assign fifo_aempty = (count_r <= AEMPTY_V);
  assign fifo_count  = count_r;
  assign Data_out    = data_out_r;
  assign o_rvalid    = rvalid_r;

  // No bypass: a read against an empty FIFO is rejected even if a write lands on the same edge.
  assign wr_acc_s = i_wreq & ~full_s;
  assign rd_acc_s = i_rreq & ~empty_s;

  // Occupancy next-state from the accepted operations.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array; deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wptr_r] <= Data_in;
    end
  end

  // Pointers and counter; AW-bit pointers wrap DEPTH-1 -> 0 naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_acc_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
    end
  end

  // Registered read port: data holds when no read is accepted, valid pulses for one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_r <= {WIDTH{1'b0}};
      rvalid_r   <= 1'b0;
    end else begin
      if (rd_acc_s) begin
        data_out_r <= mem_r[rptr_r];
      end
      rvalid_r <= rd_acc_s;
    end
  end

`ifdef SFIFO_ERR_EN
  logic ovf_r;
  logic udf_r;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r | (i_wreq & full_s);
      udf_r <= udf_r | (i_rreq & empty_s);
    end
  end

  assign o_ovf = ovf_r;
  assign o_udf = udf_r;
`else
  assign o_ovf = 1'b0;
  assign o_udf = 1'b0;
`endif

endmodule

// File: tb/tb_sfifo_param.sv
// Self-checking bench for sfifo_param: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_sfifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;
  localparam int AET   = 2;

  logic             clk;
  logic             reset_n;
  logic             i_wreq;
  logic             i_rreq;
  logic [WIDTH-1:0] Data_in;
  logic [WIDTH-1:0] Data_out;
  logic             o_rvalid;
  logic             fifoisfull;
  logic             fifoisempty;
  logic             fifo_afull;
  logic             fifo_aempty;
  logic [3:0]       fifo_count;
  logic             o_ovf;
  logic             o_udf;

  sfifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFT), .AEMPTY_TH(AET)) dut (
    .clk(clk), .reset_n(reset_n), .i_wreq(i_wreq), .i_rreq(i_rreq), .Data_in(Data_in),
    .Data_out(Data_out), .o_rvalid(o_rvalid), .fifoisfull(fifoisfull), .fifoisempty(fifoisempty),
    .fifo_afull(fifo_afull), .fifo_aempty(fifo_aempty), .fifo_count(fifo_count),
    .o_ovf(o_ovf), .o_udf(o_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model state
  int   q[$];
  int   m_dout;
  logic m_rvalid;
  logic m_ovf;
  logic m_udf;

  typedef struct {
    logic wreq;
    logic rreq;
    int   din;
    int   exp_dout;
    logic exp_rvalid;
    int   exp_count;
    logic exp_full;
    logic exp_afull;
    logic exp_aempty;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout   = 0;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    chk({tag, ".dout"},   int'(Data_out),    m_dout);
    chk({tag, ".rvalid"}, int'(o_rvalid),    int'(m_rvalid));
    chk({tag, ".count"},  int'(fifo_count),  n);
    chk({tag, ".full"},   int'(fifoisfull),  int'(n == DEPTH));
    chk({tag, ".empty"},  int'(fifoisempty), int'(n == 0));
    chk({tag, ".afull"},  int'(fifo_afull),  int'(n >= AFT));
    chk({tag, ".aempty"}, int'(fifo_aempty), int'(n <= AET));
`ifdef SFIFO_ERR_EN
    chk({tag, ".ovf"},    int'(o_ovf),       int'(m_ovf));
    chk({tag, ".udf"},    int'(o_udf),       int'(m_udf));
`else
    chk({tag, ".ovf"},    int'(o_ovf),       0);
    chk({tag, ".udf"},    int'(o_udf),       0);
`endif
  endtask

  // One clock cycle: drive at negedge, update model for the edge, sample 1 time unit after it.
  task automatic step(input logic w, input logic r, input int d, input string tag);
    bit full_b;
    bit empty_b;
    @(negedge clk);
    i_wreq  = w;
    i_rreq  = r;
    Data_in = WIDTH'(d);
    full_b  = (q.size() == DEPTH);
    empty_b = (q.size() == 0);
    @(posedge clk);
    if (w && full_b)  m_ovf = 1'b1;
    if (r && empty_b) m_udf = 1'b1;
    m_rvalid = 1'b0;
    if (r && !empty_b) begin
      m_dout   = q.pop_front();
      m_rvalid = 1'b1;
    end
    if (w && !full_b) q.push_back(d & 8'hFF);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_wreq  = 1'b0;
    i_rreq  = 1'b0;
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    i_wreq   = 1'b0;
    i_rreq   = 1'b0;
    Data_in  = 8'h00;
    reset_n  = 1'b0;
    model_reset();
    #12;
    check_model("reset");
    chk("reset.empty_const", int'(fifoisempty), 1);
    chk("reset.aempty_const", int'(fifo_aempty), 1);
    reset_n = 1'b1;

    // Fill with 0x11..0x88 then drain, with hand-derived expectations
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{wreq: 1'b1, rreq: 1'b0, din: (i + 1) * 8'h11, exp_dout: 0, exp_rvalid: 1'b0,
                  exp_count: i + 1, exp_full: (i == 7), exp_afull: (i + 1 >= 6),
                  exp_aempty: (i + 1 <= 2)};
    end
    for (int j = 0; j < 8; j++) begin
      vecs[8 + j] = '{wreq: 1'b0, rreq: 1'b1, din: 0, exp_dout: (j + 1) * 8'h11, exp_rvalid: 1'b1,
                      exp_count: 7 - j, exp_full: 1'b0, exp_afull: (7 - j >= 6),
                      exp_aempty: (7 - j <= 2)};
    end
    for (int k = 0; k < 16; k++) begin
      step(vecs[k].wreq, vecs[k].rreq, vecs[k].din, "vec");
      chk("vec.dout",   int'(Data_out),    vecs[k].exp_dout);
      chk("vec.rvalid", int'(o_rvalid),    int'(vecs[k].exp_rvalid));
      chk("vec.count",  int'(fifo_count),  vecs[k].exp_count);
      chk("vec.full",   int'(fifoisfull),  int'(vecs[k].exp_full));
      chk("vec.afull",  int'(fifo_afull),  int'(vecs[k].exp_afull));
      chk("vec.aempty", int'(fifo_aempty), int'(vecs[k].exp_aempty));
    end
    step(1'b0, 1'b0, 0, "idle_hold");
    chk("idle_hold.dout", int'(Data_out), 8'h88);
    chk("idle_hold.rvalid", int'(o_rvalid), 0);

    // Read while empty, then simultaneous request while empty (write only, no bypass)
    step(1'b0, 1'b1, 0, "rd_empty");
    step(1'b1, 1'b1, 8'hA5, "both_empty");
    chk("both_empty.count", int'(fifo_count), 1);
    chk("both_empty.rvalid", int'(o_rvalid), 0);
    chk("both_empty.dout", int'(Data_out), 8'h88);

    // Fill to full, then simultaneous request while full (read only)
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'hB0 + i, "fill");
    step(1'b1, 1'b1, 8'hEE, "both_full");
    chk("both_full.count", int'(fifo_count), 7);
    chk("both_full.dout", int'(Data_out), 8'hA5);
    step(1'b1, 1'b0, 8'hC0, "refill");
    step(1'b1, 1'b0, 8'hDD, "wr_full");
    chk("wr_full.count", int'(fifo_count), 8);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 0, "drain");
    chk("drain.last", int'(Data_out), 8'hC0);

    // Streaming at count 4 across pointer wrap
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h40 + i, "pre4");
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'h50 + i, "stream");
      chk("stream.count", int'(fifo_count), 4);
    end
    chk("stream.last", int'(Data_out), 8'h5F);

    // Asynchronous reset mid-burst at count 5
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h60 + i, "burst");
    step(1'b1, 1'b1, 8'h70, "burst_rd");
    step(1'b1, 1'b0, 8'h71, "burst6");
    step(1'b0, 1'b1, 0, "burst_rd2");
    chk("burst.count5", int'(fifo_count), 5);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_model("async_rst");
    chk("async_rst.count", int'(fifo_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b1, 0, "post_rst_rd");

    // Randomized traffic against the queue model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int mode;
      logic w;
      logic r;
      mode = (i / 100) % 3;
      w = ($urandom_range(99, 0) < (mode == 0 ? 70 : (mode == 1 ? 30 : 50)));
      r = ($urandom_range(99, 0) < (mode == 0 ? 30 : (mode == 1 ? 70 : 50)));
      step(w, r, int'($urandom_range(255, 0)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sfifo_param.md
SFIFO_PARAM -- requirements
Module: sfifo_param

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of entries; power of two, >=2; AW = log2(DEPTH).
REQ-003 Parameter AFULL_TH, default 6, almost-full threshold in entries (1..DEPTH).
REQ-004 Parameter AEMPTY_TH, default 2, almost-empty threshold in entries (0..DEPTH-1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 i_wreq  input  1  write request.
REQ-008 i_rreq  input  1  read request.
REQ-009 Data_in  input  WIDTH  write data.
REQ-010 Data_out  output  WIDTH  registered read data.
REQ-011 o_rvalid  output  1  Data_out updated by the previous cycle's accepted read.
REQ-012 fifoisfull  output  1  count == DEPTH.
REQ-013 fifoisempty  output  1  count == 0.
REQ-014 fifo_afull  output  1  count >= AFULL_TH.
REQ-015 fifo_aempty  output  1  count <= AEMPTY_TH.
REQ-016 fifo_count  output  AW+1  current occupancy, 0..DEPTH.
REQ-017 o_ovf  output  1  sticky overflow error.
REQ-018 o_udf  output  1  sticky underflow error.

Function
REQ-019 Write accepted iff i_wreq=1 and fifoisfull=0 at the clock edge; stores Data_in at write pointer, pointer +1.
REQ-020 Read accepted iff i_rreq=1 and fifoisempty=0; Data_out <= entry at read pointer, pointer +1; latency one cycle.
REQ-021 Data_out holds its value when no read is accepted.
REQ-022 o_rvalid = 1 for exactly the cycle after each accepted read, else 0.
REQ-023 Pointers AW bits wide; wrap DEPTH-1 -> 0 with no gap.
REQ-024 fifo_count: +1 on write-only accept, -1 on read-only accept, unchanged on simultaneous accept or no accept; never exceeds DEPTH nor goes below 0.
REQ-025 Simultaneous request while full: read accepted, write rejected; count becomes DEPTH-1.
REQ-026 Simultaneous request while empty: write accepted, read rejected (no bypass); count becomes 1, Data_out unchanged, o_rvalid 0.
REQ-027 Status flags combinational from fifo_count only; no glitch-dependent logic on inputs.
REQ-028 Rejected requests leave memory, pointers and count unchanged.

Reset
REQ-029 reset_n=0 immediately clears pointers, fifo_count, Data_out, o_rvalid, o_ovf, o_udf to 0, independent of clk.
REQ-030 During/after reset: fifoisempty=1, fifoisfull=0, fifo_aempty=1, fifo_afull=0.
REQ-031 Memory contents not reset; reset mid-operation discards all stored entries.

Configuration
REQ-032 Macro SFIFO_ERR_EN defined: o_ovf set on any edge with i_wreq=1 and fifoisfull=1; o_udf set on any edge with i_rreq=1 and fifoisempty=1; both held until reset.
REQ-033 Macro SFIFO_ERR_EN undefined: o_ovf and o_udf tied 0; no error-flag flops; all other behaviour identical.

Verification
REQ-034 Defaults; reset, write 0x11..0x88 over 8 cycles -> fifoisfull=1, fifo_count=8, fifo_afull asserted from count 6.
REQ-035 From full, read 8 times -> Data_out 0x11..0x88 in order, each one cycle after request with o_rvalid=1; ends empty, fifo_aempty from count 2.
REQ-036 At count 4, hold i_wreq=i_rreq=1 for 20 cycles with incrementing data -> fifo_count stays 4, output order preserved across pointer wrap.
REQ-037 Full + both requests -> count 7, write data dropped; empty + both requests -> count 1, o_rvalid 0, Data_out unchanged.
REQ-038 SFIFO_ERR_EN: write at full -> o_ovf=1 and stays 1 after draining; read at empty -> o_udf=1; reset_n pulse low mid-burst (count 5) -> all outputs cleared asynchronously, count 0.
